// File: rtl/maze_move_probe.sv
// Per-frame player move validator: probes destination pixels against the maze wall
// decoder and commits the move only if all are clear. Define MAZE_PROBE_FULL_BOX_EN to scan the whole box.
module maze_move_probe #(
    parameter int unsigned BOX_SIZE = 4,
    parameter int unsigned STEP     = 1,
    parameter logic [9:0]  START_X  = 10'd267,
    parameter logic [9:0]  START_Y  = 10'd187
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       move_req,
    input  logic [1:0] dir,
    output logic [9:0] probe_x,
    output logic [9:0] probe_y,
    input  logic       probe_hit,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       busy,
    output logic       moved,
    output logic       blocked
);

    localparam int unsigned CW = 10;
    localparam int unsigned XW = 11;
    localparam int unsigned KW = 5;

    localparam logic [XW-1:0] X_MAX  = XW'(639);
    localparam logic [XW-1:0] Y_MAX  = XW'(479);
    localparam logic [CW-1:0] STEP_W = CW'(STEP);
    localparam logic [CW-1:0] EDGE   = CW'(BOX_SIZE - 1);
    localparam logic [XW-1:0] REACH  = XW'(STEP + BOX_SIZE - 1);
    localparam logic [KW-1:0] K_LAST = KW'(BOX_SIZE - 1);

    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_COMMIT, S_REJECT} state_t;

    state_t        state;
    logic          sync1, sync2, sync3;
    logic          fe;
    logic [CW-1:0] cx, cy;
    logic [KW-1:0] k_i;
`ifdef MAZE_PROBE_FULL_BOX_EN
    logic [KW-1:0] k_j;
`else
    logic [1:0]    dir_q;
`endif

    logic [CW-1:0] cand_x, cand_y;
    logic [CW-1:0] first_x, first_y;
    logic          range_ok;
    logic          probe_last;

    // frame_clk is asynchronous: two-flop synchronizer plus rising-edge detect
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= frame_clk;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign fe = sync2 & ~sync3;

    // Candidate position, range check (11-bit so wrap can never pass) and first probe pixel
    always_comb begin
        cand_x   = pos_x;
        cand_y   = pos_y;
        range_ok = 1'b0;
        case (dir)
            2'b00: begin
                cand_y   = pos_y - STEP_W;
                range_ok = ({1'b0, pos_y} >= {1'b0, STEP_W});
            end
            2'b01: begin
                cand_y   = pos_y + STEP_W;
                range_ok = (({1'b0, pos_y} + REACH) <= Y_MAX);
            end
            2'b10: begin
                cand_x   = pos_x - STEP_W;
                range_ok = ({1'b0, pos_x} >= {1'b0, STEP_W});
            end
            default: begin
                cand_x   = pos_x + STEP_W;
                range_ok = (({1'b0, pos_x} + REACH) <= X_MAX);
            end
        endcase

        first_x = cand_x;
        first_y = cand_y;
`ifndef MAZE_PROBE_FULL_BOX_EN
        if (dir == 2'b01) first_y = cand_y + EDGE;
        if (dir == 2'b11) first_x = cand_x + EDGE;
`endif
    end

`ifdef MAZE_PROBE_FULL_BOX_EN
    assign probe_last = (k_i == K_LAST) && (k_j == K_LAST);
`else
    assign probe_last = (k_i == K_LAST);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            pos_x   <= START_X;
            pos_y   <= START_Y;
            probe_x <= '0;
            probe_y <= '0;
            busy    <= 1'b0;
            moved   <= 1'b0;
            blocked <= 1'b0;
            cx      <= '0;
            cy      <= '0;
            k_i     <= '0;
`ifdef MAZE_PROBE_FULL_BOX_EN
            k_j     <= '0;
`else
            dir_q   <= 2'b00;
`endif
        end else begin
            moved   <= 1'b0;
            blocked <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fe && move_req) begin
                        cx   <= cand_x;
                        cy   <= cand_y;
                        k_i  <= '0;
                        busy <= 1'b1;
`ifdef MAZE_PROBE_FULL_BOX_EN
                        k_j  <= '0;
`else
                        dir_q <= dir;
`endif
                        if (range_ok) begin
                            probe_x <= first_x;
                            probe_y <= first_y;
                            state   <= S_PROBE;
                        end else begin
                            blocked <= 1'b1;
                            state   <= S_REJECT;
                        end
                    end
                end
                S_PROBE: begin
                    if (probe_hit) begin
                        blocked <= 1'b1;
                        state   <= S_REJECT;
                    end else if (probe_last) begin
                        moved <= 1'b1;
                        state <= S_COMMIT;
                    end else begin
`ifdef MAZE_PROBE_FULL_BOX_EN
                        // Row-major walk: i inner along X, j outer along Y
                        if (k_i == K_LAST) begin
                            k_i     <= '0;
                            k_j     <= k_j + KW'(1);
                            probe_x <= cx;
                            probe_y <= probe_y + CW'(1);
                        end else begin
                            k_i     <= k_i + KW'(1);
                            probe_x <= probe_x + CW'(1);
                        end
`else
                        // Vertical moves walk the edge along X, horizontal moves along Y
                        k_i <= k_i + KW'(1);
                        if (dir_q[1]) probe_y <= probe_y + CW'(1);
                        else          probe_x <= probe_x + CW'(1);
`endif
                    end
                end
                S_COMMIT: begin
                    pos_x <= cx;
                    pos_y <= cy;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_REJECT: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maze_move_probe.sv
// Directed bench for maze_move_probe (leading-edge build): vector table of frame
// requests plus hand-written reset sequences, against a small maze wall model.
module tb_maze_move_probe;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       move_req_a, move_req_b;
    logic [1:0] dir_a, dir_b;
    logic [9:0] probe_x_a, probe_y_a, pos_x_a, pos_y_a;
    logic [9:0] probe_x_b, probe_y_b, pos_x_b, pos_y_b;
    logic       hit_a, hit_b;
    logic       busy_a, moved_a, blocked_a;
    logic       busy_b, moved_b, blocked_b;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int sel_r     = 0;

    always #5 Clk = ~Clk;

    // Wall model: right wall from x=275, top wall up to y=185, one stray wall pixel at (270,189)
    assign hit_a = (probe_x_a >= 10'd275) || (probe_y_a <= 10'd185) ||
                   ((probe_x_a == 10'd270) && (probe_y_a == 10'd189));
    assign hit_b = 1'b0;

    maze_move_probe dut_a (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .move_req(move_req_a), .dir(dir_a),
        .probe_x(probe_x_a), .probe_y(probe_y_a), .probe_hit(hit_a),
        .pos_x(pos_x_a), .pos_y(pos_y_a),
        .busy(busy_a), .moved(moved_a), .blocked(blocked_a)
    );

    maze_move_probe #(.START_X(10'd0), .START_Y(10'd476)) dut_b (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .move_req(move_req_b), .dir(dir_b),
        .probe_x(probe_x_b), .probe_y(probe_y_b), .probe_hit(hit_b),
        .pos_x(pos_x_b), .pos_y(pos_y_b),
        .busy(busy_b), .moved(moved_b), .blocked(blocked_b)
    );

    logic [9:0] s_px, s_py, s_qx, s_qy;
    logic       s_busy, s_moved, s_blocked;
    assign s_px      = (sel_r != 0) ? pos_x_b     : pos_x_a;
    assign s_py      = (sel_r != 0) ? pos_y_b     : pos_y_a;
    assign s_qx      = (sel_r != 0) ? probe_x_b   : probe_x_a;
    assign s_qy      = (sel_r != 0) ? probe_y_b   : probe_y_a;
    assign s_busy    = (sel_r != 0) ? busy_b      : busy_a;
    assign s_moved   = (sel_r != 0) ? moved_b     : moved_a;
    assign s_blocked = (sel_r != 0) ? blocked_b   : blocked_a;

    // kind: 0 no pulse, 1 moved, 2 blocked; lat: pulse cycle relative to the frame edge cycle E
    typedef struct {
        int         sel;
        logic [1:0] dir;
        logic       req;
        int         kind;
        int         lat;
        int         busy_n;
        int         px, py, qx, qy;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else pass_cnt++;
    endtask

    // frame_clk rises #1 after posedge 0; fe is high in the cycle after posedge 2 (cycle E)
    task automatic run_vec(input vec_t v, input int idx);
        int mcnt = 0;
        int bcnt = 0;
        int lat  = -1;
        int bsy  = 0;
        int kind;
        sel_r = v.sel;
        @(posedge Clk); #1;
        if (v.sel == 0) begin move_req_a = v.req; dir_a = v.dir; end
        else            begin move_req_b = v.req; dir_b = v.dir; end
        frame_clk = 1'b1;
        for (int p = 1; p <= 24; p++) begin
            @(posedge Clk); @(negedge Clk);
            if (s_busy) bsy++;
            if (s_moved) begin mcnt++; if (lat < 0) lat = p - 2; end
            if (s_blocked) begin bcnt++; if (lat < 0) lat = p - 2; end
        end
        frame_clk  = 1'b0;
        move_req_a = 1'b0;
        move_req_b = 1'b0;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        if (mcnt == 0 && bcnt == 0)      kind = 0;
        else if (mcnt == 1 && bcnt == 0) kind = 1;
        else if (mcnt == 0 && bcnt == 1) kind = 2;
        else                             kind = 9;
        check($sformatf("v%0d pulse_kind", idx), kind, v.kind);
        if (v.kind != 0) check($sformatf("v%0d pulse_cycle", idx), lat, v.lat);
        check($sformatf("v%0d busy_cycles", idx), bsy, v.busy_n);
        check($sformatf("v%0d pos_x", idx), int'(s_px), v.px);
        check($sformatf("v%0d pos_y", idx), int'(s_py), v.py);
        check($sformatf("v%0d probe_x", idx), int'(s_qx), v.qx);
        check($sformatf("v%0d probe_y", idx), int'(s_qy), v.qy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        //          sel dir    req  kind lat busy  px   py   qx   qy
        vecs[0]  = '{0, 2'b11, 1'b1, 1, 5, 5, 268, 187, 271, 190};
        vecs[1]  = '{0, 2'b11, 1'b1, 1, 5, 5, 269, 187, 272, 190};
        vecs[2]  = '{0, 2'b11, 1'b1, 1, 5, 5, 270, 187, 273, 190};
        vecs[3]  = '{0, 2'b11, 1'b1, 1, 5, 5, 271, 187, 274, 190};
        vecs[4]  = '{0, 2'b11, 1'b1, 2, 2, 2, 271, 187, 275, 187};
        vecs[5]  = '{0, 2'b00, 1'b1, 1, 5, 5, 271, 186, 274, 186};
        vecs[6]  = '{0, 2'b00, 1'b1, 2, 2, 2, 271, 186, 271, 185};
        vecs[7]  = '{0, 2'b00, 1'b0, 0, 0, 0, 271, 186, 271, 185};
        vecs[8]  = '{0, 2'b01, 1'b0, 0, 0, 0, 271, 186, 271, 185};
        vecs[9]  = '{0, 2'b11, 1'b0, 0, 0, 0, 271, 186, 271, 185};
        vecs[10] = '{0, 2'b01, 1'b1, 1, 5, 5, 271, 187, 274, 190};
        vecs[11] = '{0, 2'b10, 1'b1, 2, 4, 4, 271, 187, 270, 189};
        vecs[12] = '{0, 2'b11, 1'b1, 2, 2, 2, 271, 187, 275, 187};
        vecs[13] = '{1, 2'b10, 1'b1, 2, 1, 1,   0, 476,   0,   0};
        vecs[14] = '{1, 2'b01, 1'b1, 2, 1, 1,   0, 476,   0,   0};
        vecs[15] = '{1, 2'b00, 1'b1, 1, 5, 5,   0, 475,   3, 475};
        vecs[16] = '{1, 2'b01, 1'b1, 1, 5, 5,   0, 476,   3, 479};
        vecs[17] = '{1, 2'b01, 1'b1, 2, 1, 1,   0, 476,   3, 479};
        vecs[18] = '{1, 2'b11, 1'b1, 1, 5, 5,   1, 476,   4, 479};

        Reset      = 1'b1;
        frame_clk  = 1'b0;
        move_req_a = 1'b0;
        move_req_b = 1'b0;
        dir_a      = 2'b00;
        dir_b      = 2'b00;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check("reset pos_x", int'(pos_x_a), 267);
        check("reset pos_y", int'(pos_y_a), 187);
        check("reset busy", int'(busy_a), 0);
        check("reset moved", int'(moved_a), 0);
        check("reset blocked", int'(blocked_a), 0);
        check("reset probe_x", int'(probe_x_a), 0);
        check("reset probe_y", int'(probe_y_a), 0);
        check("reset b pos_x", int'(pos_x_b), 0);
        check("reset b pos_y", int'(pos_y_b), 476);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Reset lands in cycle E+2 of a clean down move: no pulse, position back to start
        sel_r  = 0;
        pulses = 0;
        @(posedge Clk); #1;
        move_req_a = 1'b1;
        dir_a      = 2'b01;
        frame_clk  = 1'b1;
        for (int p = 1; p <= 4; p++) begin
            @(posedge Clk); @(negedge Clk);
            if (moved_a || blocked_a) pulses++;
            if (p == 3) check("midreset busy_at_E+1", int'(busy_a), 1);
        end
        #1;
        Reset      = 1'b1;
        frame_clk  = 1'b0;
        move_req_a = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("midreset busy", int'(busy_a), 0);
        check("midreset pos_x", int'(pos_x_a), 267);
        check("midreset pos_y", int'(pos_y_a), 187);
        check("midreset probe_x", int'(probe_x_a), 0);
        for (int p = 0; p < 10; p++) begin
            @(negedge Clk);
            if (moved_a || blocked_a || busy_a) pulses++;
        end
        check("midreset no_pulse", pulses, 0);

        for (int i = 13; i < NV; i++) run_vec(vecs[i], i);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
